seq_wr: RTL and testbench
=========================

SEQ_WR -- requirements
Module: seq_wr

Interface
REQ-001 The block SHALL have parameter HEADER, default 8'hA5: frame header byte, sent first.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 8: minimum idle cycles after a frame, range 1..255.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start  input  1  frame request, sampled on the clk rising edge.
REQ-006 The block SHALL have ports in_data0, in_data1, in_data2, in_data3  input  8 each  payload bytes, sent in index order.
REQ-007 The block SHALL have port data_out  output  1  serial frame bit, one bit per clk, MSB first within each byte.
REQ-008 The block SHALL have port busy  output  1  high from the cycle after start is accepted through the last GAP cycle.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 The FSM SHALL have exactly five states: IDLE, HEAD, DATA, CHK, GAP.
REQ-011 In IDLE, start=1 SHALL be accepted: in_data0..3 latched into an internal 32-bit shift register, next state HEAD.
REQ-012 Latency SHALL be one cycle: data_out carries HEADER[7] in the cycle immediately after the accepting edge.
REQ-013 HEAD SHALL last 8 cycles and output HEADER[7..0]; DATA SHALL last 32 cycles and output in_data0[7..0], in_data1, in_data2, then in_data3, MSB first.
REQ-014 CHK SHALL last 8 cycles and output the checksum, MSB first; checksum = (in_data0+in_data1+in_data2+in_data3) mod 256, computed from the latched values.
REQ-015 A bit counter SHALL count 0..7 per byte and a byte index 0..3 SHALL be used in DATA; both SHALL wrap to 0 on each state exit.
REQ-016 GAP SHALL last exactly GAP_CYCLES cycles with data_out=0, then return to IDLE.
REQ-017 done SHALL be high only in the first GAP cycle.
REQ-018 data_out SHALL be 0 in IDLE and GAP.
REQ-019 start while busy=1 SHALL be ignored; it is not queued, and input changes during a frame SHALL NOT affect the frame in flight.
REQ-020 start held high continuously SHALL produce back-to-back frames separated by exactly GAP_CYCLES idle cycles plus one IDLE cycle.
REQ-021 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state IDLE, data_out=0, busy=0, done=0, and all counters and the shift register to 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse; after release, the first start SHALL send a complete new frame.

Configuration
REQ-024 With macro SEQ_WR_CHECKSUM_EN defined, the CHK state and checksum byte SHALL be present, giving a frame length of 48 bits.
REQ-025 Without SEQ_WR_CHECKSUM_EN, DATA SHALL transition directly to GAP, giving a frame length of 40 bits, and the checksum logic SHALL be omitted.

Verification
REQ-026 Basic frame: rst_n low 15 ns, then start pulse with data 01,02,03,04 -> serial bits A5 01 02 03 04 0A, MSB first, from the next cycle; done pulses in cycle 49 after acceptance.
REQ-027 Checksum wrap: data FF,FF,FF,FF -> checksum byte FC; with the macro undefined -> 40-bit frame, no checksum, done in cycle 41.
REQ-028 Busy guard: second start pulse at bit 20 of a frame with different data -> ignored; frame unchanged, single done pulse.
REQ-029 Continuous start with GAP_CYCLES=8 -> consecutive headers start exactly 48+8+1=57 cycles apart.
REQ-030 Reset at bit 30 of a frame -> data_out and busy go 0 without a clock edge, no done pulse; next start sends a full correct frame.
REQ-031 Loopback: drive the existing sequence reader with this block's output -> its out_data0..3 match the sent bytes and out_check_flag asserts.

Source files
------------

// File: rtl/seq_wr.sv
// seq_wr: serial frame writer sending header, four payload bytes, optional checksum, then an idle gap.
// Define SEQ_WR_CHECKSUM_EN to append the checksum byte (48-bit frame instead of 40-bit).
module seq_wr #(
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data0,
  input  logic [7:0] in_data1,
  input  logic [7:0] in_data2,
  input  logic [7:0] in_data3,
  output logic       data_out,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HEAD = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef SEQ_WR_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd3;
`endif
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [2:0]  r_state;
  logic [2:0]  r_bit_cnt;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_gap_cnt;
  logic [31:0] r_shift;
  logic        r_data_out;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  w_bit_inc;
  logic        w_data_last;

  assign w_bit_inc   = r_bit_cnt + 3'd1;
  assign w_data_last = (r_byte_idx == 2'd3) && (r_bit_cnt == 3'd7);

`ifdef SEQ_WR_CHECKSUM_EN
  logic [7:0] r_chk;
  logic [7:0] w_sum;
  assign w_sum = in_data0 + in_data1 + in_data2 + in_data3;
`endif

  // data_out is loaded one edge ahead with the bit that the next cycle must carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_byte_idx <= 2'd0;
      r_gap_cnt  <= 8'd0;
      r_shift    <= 32'd0;
      r_data_out <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef SEQ_WR_CHECKSUM_EN
      r_chk      <= 8'd0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_data_out <= 1'b0;
          if (start) begin
            r_state    <= S_HEAD;
            r_busy     <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= {in_data0, in_data1, in_data2, in_data3};
            r_data_out <= HEADER[7];
`ifdef SEQ_WR_CHECKSUM_EN
            r_chk      <= w_sum;
`endif
          end
        end
        S_HEAD: begin
          if (r_bit_cnt == 3'd7) begin
            r_state    <= S_DATA;
            r_bit_cnt  <= 3'd0;
            r_data_out <= r_shift[31];
            r_shift    <= {r_shift[30:0], 1'b0};
          end else begin
            r_bit_cnt  <= w_bit_inc;
            r_data_out <= HEADER[3'd7 - w_bit_inc];
          end
        end
        S_DATA: begin
          if (w_data_last) begin
            r_bit_cnt  <= 3'd0;
            r_byte_idx <= 2'd0;
`ifdef SEQ_WR_CHECKSUM_EN
            r_state    <= S_CHK;
            r_data_out <= r_chk[7];
            r_chk      <= {r_chk[6:0], 1'b0};
`else
            r_state    <= S_GAP;
            r_data_out <= 1'b0;
            r_done     <= 1'b1;
            r_gap_cnt  <= 8'd0;
`endif
          end else begin
            r_bit_cnt  <= w_bit_inc;
            if (r_bit_cnt == 3'd7) begin
              r_byte_idx <= r_byte_idx + 2'd1;
            end
            r_data_out <= r_shift[31];
            r_shift    <= {r_shift[30:0], 1'b0};
          end
        end
`ifdef SEQ_WR_CHECKSUM_EN
        S_CHK: begin
          if (r_bit_cnt == 3'd7) begin
            r_state    <= S_GAP;
            r_bit_cnt  <= 3'd0;
            r_data_out <= 1'b0;
            r_done     <= 1'b1;
            r_gap_cnt  <= 8'd0;
          end else begin
            r_bit_cnt  <= w_bit_inc;
            r_data_out <= r_chk[7];
            r_chk      <= {r_chk[6:0], 1'b0};
          end
        end
`endif
        S_GAP: begin
          r_data_out <= 1'b0;
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_gap_cnt <= 8'd0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_data_out <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = r_data_out;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_seq_wr.sv
// Directed self-checking bench for seq_wr: frame content, done/busy timing, busy guard,
// back-to-back frames and asynchronous reset mid-frame.
module tb_seq_wr;

`ifdef SEQ_WR_CHECKSUM_EN
  localparam int FRAME_BITS = 48;
`else
  localparam int FRAME_BITS = 40;
`endif
  localparam int GAP = 8;
  localparam int WIN = FRAME_BITS + GAP + 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] in_data0;
  logic [7:0] in_data1;
  logic [7:0] in_data2;
  logic [7:0] in_data3;
  logic       data_out;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  seq_wr #(.HEADER(8'hA5), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data0 (in_data0),
    .in_data1 (in_data1),
    .in_data2 (in_data2),
    .in_data3 (in_data3),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Drop the checksum byte when the frame is built without it.
  function automatic logic [47:0] trim(input logic [47:0] full);
    trim = full;
    if (FRAME_BITS == 40) trim = {full[47:8], 8'h00};
  endfunction

  // Starts a frame and records the window up to the first IDLE cycle; optional start poke mid-frame.
  task automatic run_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] d3, input int poke_cyc,
                           output logic [47:0] bits, output int done_first, output int done_cnt,
                           output int busy_low_first, output logic busy_c1);
    @(negedge clk);
    in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
    start = 1'b1;
    bits = '0; done_first = 0; done_cnt = 0; busy_low_first = 0; busy_c1 = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      if (c <= FRAME_BITS) bits = {bits[46:0], data_out};
      if (c == 1) busy_c1 = busy;
      if (done) begin
        done_cnt++;
        if (done_first == 0) done_first = c;
      end
      if (!busy && busy_low_first == 0) busy_low_first = c;
      start = 1'b0;
      if (c == poke_cyc) begin
        start = 1'b1;
        in_data0 = ~d0; in_data1 = ~d1; in_data2 = ~d2; in_data3 = ~d3;
      end
    end
    bits = bits << (48 - FRAME_BITS);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    in_data0 = 8'h00; in_data1 = 8'h00; in_data2 = 8'h00; in_data3 = 8'h00;
    #15;
    checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL reset_data_out got %b exp 0", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: data_out=%b busy=%b done=%b", data_out, busy, done);
  endtask

  task automatic test_basic_frame();
    logic [47:0] bits, exp_bits, full;
    int df, dc, blf;
    logic b1;
    full = 48'hA5_01_02_03_04_0A;
    exp_bits = trim(full);
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 0, bits, df, dc, blf, b1);
    checks++; if (bits !== exp_bits) begin errors++; $display("FAIL basic_bits got %h exp %h", bits, exp_bits); end
    checks++; if (df != FRAME_BITS + 1) begin errors++; $display("FAIL basic_done_cycle got %0d exp %0d", df, FRAME_BITS + 1); end
    checks++; if (dc != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", dc); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy_first got %b exp 1", b1); end
    checks++; if (blf != WIN) begin errors++; $display("FAIL basic_busy_end got %0d exp %0d", blf, WIN); end
    $display("basic: bits=%h done_cycle=%0d busy_low=%0d", bits, df, blf);
  endtask

  task automatic test_checksum_wrap();
    logic [47:0] bits, exp_bits, full;
    int df, dc, blf;
    logic b1;
    full = 48'hA5_FF_FF_FF_FF_FC;
    exp_bits = trim(full);
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, bits, df, dc, blf, b1);
    checks++; if (bits !== exp_bits) begin errors++; $display("FAIL wrap_bits got %h exp %h", bits, exp_bits); end
    checks++; if (df != FRAME_BITS + 1) begin errors++; $display("FAIL wrap_done_cycle got %0d exp %0d", df, FRAME_BITS + 1); end
    checks++; if (dc != 1) begin errors++; $display("FAIL wrap_done_count got %0d exp 1", dc); end
    $display("wrap: bits=%h done_cycle=%0d", bits, df);
  endtask

  task automatic test_busy_guard();
    logic [47:0] bits, exp_bits, full;
    int df, dc, blf, extra_busy;
    logic b1;
    full = 48'hA5_11_22_33_44_AA;
    exp_bits = trim(full);
    run_frame(8'h11, 8'h22, 8'h33, 8'h44, 20, bits, df, dc, blf, b1);
    checks++; if (bits !== exp_bits) begin errors++; $display("FAIL guard_bits got %h exp %h", bits, exp_bits); end
    checks++; if (dc != 1) begin errors++; $display("FAIL guard_done_count got %0d exp 1", dc); end
    checks++; if (df != FRAME_BITS + 1) begin errors++; $display("FAIL guard_done_cycle got %0d exp %0d", df, FRAME_BITS + 1); end
    extra_busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || data_out) extra_busy++;
    end
    checks++; if (extra_busy != 0) begin errors++; $display("FAIL guard_queued got %0d busy cycles exp 0", extra_busy); end
    $display("guard: bits=%h done_count=%0d queued=%0d", bits, dc, extra_busy);
  endtask

  task automatic test_back_to_back();
    logic [47:0] f1, f2, exp_bits, full;
    int busy_low_cnt, busy_low_first, done_cnt, waited;
    full = 48'hA5_5A_C3_0F_F0_1C;
    exp_bits = trim(full);
    f1 = '0; f2 = '0;
    busy_low_cnt = 0; busy_low_first = 0; done_cnt = 0;
    @(negedge clk);
    in_data0 = 8'h5A; in_data1 = 8'hC3; in_data2 = 8'h0F; in_data3 = 8'hF0;
    start = 1'b1;
    for (int c = 1; c <= WIN + FRAME_BITS; c++) begin
      @(negedge clk);
      if (c <= FRAME_BITS) f1 = {f1[46:0], data_out};
      if (c > WIN) f2 = {f2[46:0], data_out};
      if (!busy) begin
        busy_low_cnt++;
        if (busy_low_first == 0) busy_low_first = c;
      end
      if (done) done_cnt++;
    end
    start = 1'b0;
    f1 = f1 << (48 - FRAME_BITS);
    f2 = f2 << (48 - FRAME_BITS);
    checks++; if (f1 !== exp_bits) begin errors++; $display("FAIL b2b_frame1 got %h exp %h", f1, exp_bits); end
    checks++; if (f2 !== exp_bits) begin errors++; $display("FAIL b2b_frame2 got %h exp %h", f2, exp_bits); end
    checks++; if (busy_low_cnt != 1) begin errors++; $display("FAIL b2b_idle_cycles got %0d exp 1", busy_low_cnt); end
    checks++; if (busy_low_first != WIN) begin errors++; $display("FAIL b2b_idle_cycle got %0d exp %0d", busy_low_first, WIN); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_count got %0d exp 1", done_cnt); end
    waited = 0;
    while (busy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain got busy=%b exp 0", busy); end
    $display("b2b: f1=%h f2=%h idle_cycle=%0d", f1, f2, busy_low_first);
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] bits, exp_bits, full;
    int df, dc, blf, stray;
    logic b1;
    @(negedge clk);
    in_data0 = 8'hFF; in_data1 = 8'hFF; in_data2 = 8'hFF; in_data3 = 8'hFF;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
    checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL midrst_data_before got %b exp 1", data_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL midrst_data_async got %b exp 0", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_async got %b exp 0", busy); end
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || busy || data_out) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles exp 0", stray); end
    full = 48'hA5_01_02_03_04_0A;
    exp_bits = trim(full);
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 0, bits, df, dc, blf, b1);
    checks++; if (bits !== exp_bits) begin errors++; $display("FAIL midrst_next_bits got %h exp %h", bits, exp_bits); end
    checks++; if (df != FRAME_BITS + 1) begin errors++; $display("FAIL midrst_next_done got %0d exp %0d", df, FRAME_BITS + 1); end
    $display("midrst: stray=%0d next_bits=%h done_cycle=%0d", stray, bits, df);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_checksum_wrap();
    test_busy_guard();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
